// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcodes, ALU codes, sequencer state codes
// and the instruction-class decode used by the control sequencer.
package cpu_defs_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  localparam logic [4:0] S_IDLE = 5'd0;
  localparam logic [4:0] S_T0   = 5'd1;
  localparam logic [4:0] S_T1   = 5'd2;
  localparam logic [4:0] S_T2   = 5'd3;
  localparam logic [4:0] S_T3   = 5'd4;
  localparam logic [4:0] S_T4   = 5'd5;
  localparam logic [4:0] S_T5   = 5'd6;
  localparam logic [4:0] S_T6   = 5'd7;
  localparam logic [4:0] S_T7   = 5'd8;
  localparam logic [4:0] S_HALT = 5'd9;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_UNARY,
    C_MULDIV,
    C_IMM,
    C_LD,
    C_ST,
    C_IN,
    C_OUT,
    C_MFHI,
    C_MFLO,
    C_HALT,
    C_NONE
  } iclass_e;

  function automatic iclass_e classify(
    input logic [4:0] op
  );
    iclass_e c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHL, OP_SHR, OP_SHRA,
      OP_ROL, OP_ROR:      c = C_RTYPE;
      OP_NEG, OP_NOT:      c = C_UNARY;
      OP_MUL, OP_DIV:      c = C_MULDIV;
      OP_ADDI, OP_ANDI,
      OP_ORI, OP_LDI:      c = C_IMM;
      OP_LD:               c = C_LD;
      OP_ST:               c = C_ST;
      OP_IN:               c = C_IN;
      OP_OUT:              c = C_OUT;
      OP_MFHI:             c = C_MFHI;
      OP_MFLO:             c = C_MFLO;
      OP_HALT:             c = C_HALT;
      default:             c = C_NONE;
    endcase
    return c;
  endfunction

  // ldi/ld/st form an address or value as Rb + C
  function automatic logic [4:0] imm_alu(
    input logic [4:0] op
  );
    logic [4:0] a;
    case (op)
      OP_ANDI: a = OP_AND;
      OP_ORI:  a = OP_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// 4-bit register field to 16-bit one-hot select, gated by an enable.
module reg_field_decoder (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch, per-class execute steps, halt.
// Outputs decode only from the state register and IR.
module control_sequencer
  import cpu_defs_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        MAR_enable,
  output logic        MDRin,
  output logic        mdr_read,
  output logic        mem_write,
  output logic        IR_enable,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHigh_enable,
  output logic        ZLow_enable,
  output logic        OutPort_enable,
  output logic [4:0]  opcode,
  output logic        halted,
  output logic [4:0]  state_out
);

  logic [4:0] state_q, state_d;
  logic [4:0] done_st;
  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic [3:0] rd_field, wr_field;
  logic       rd_en, wr_en;
  logic       unused_ir;
  iclass_e    cls;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign cls       = classify(op);
  assign state_out = state_q;
  assign halted    = (state_q == S_HALT);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    done_st = run ? S_T0 : S_IDLE;
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2: begin
        unique case (1'b1)
          cls == C_HALT: state_d = S_HALT;
          cls == C_NONE: state_d = done_st;
          default:       state_d = S_T3;
        endcase
      end
      S_T3: begin
        if (cls inside {C_IN, C_OUT,
                        C_MFHI, C_MFLO})
          state_d = done_st;
        else
          state_d = S_T4;
      end
      S_T4: begin
        if (cls == C_UNARY) state_d = done_st;
        else                state_d = S_T5;
      end
      S_T5: begin
        if (cls inside {C_RTYPE, C_IMM})
          state_d = done_st;
        else
          state_d = S_T6;
      end
      S_T6: begin
        unique case (1'b1)
          cls == C_MULDIV: state_d = done_st;
          cls == C_LD:
            if (mem_ready) state_d = S_T7;
          default:         state_d = S_T7;
        endcase
      end
      S_T7: begin
        if (cls == C_ST) begin
          if (mem_ready) state_d = done_st;
        end else begin
          state_d = done_st;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCout          = 1'b0;
    MDRout         = 1'b0;
    ZHighout       = 1'b0;
    ZLowout        = 1'b0;
    HIout          = 1'b0;
    LOout          = 1'b0;
    Cout           = 1'b0;
    InPortout      = 1'b0;
    PC_enable      = 1'b0;
    IncPC          = 1'b0;
    MAR_enable     = 1'b0;
    MDRin          = 1'b0;
    mdr_read       = 1'b0;
    mem_write      = 1'b0;
    IR_enable      = 1'b0;
    Yin            = 1'b0;
    HIin           = 1'b0;
    LOin           = 1'b0;
    ZHigh_enable   = 1'b0;
    ZLow_enable    = 1'b0;
    OutPort_enable = 1'b0;
    opcode         = 5'd0;
    rd_field       = 4'd0;
    rd_en          = 1'b0;
    wr_field       = 4'd0;
    wr_en          = 1'b0;
    unique case (state_q)
      S_T0: begin
        PCout       = 1'b1;
        MAR_enable  = 1'b1;
        IncPC       = 1'b1;
        ZLow_enable = 1'b1;
      end
      S_T1: begin
        ZLowout   = 1'b1;
        PC_enable = 1'b1;
        mdr_read  = 1'b1;
        MDRin     = 1'b1;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IR_enable = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_RTYPE, C_IMM, C_LD, C_ST: begin
            rd_field = rb;
            rd_en    = 1'b1;
            Yin      = 1'b1;
          end
          C_UNARY: begin
            rd_field    = rb;
            rd_en       = 1'b1;
            opcode      = op;
            ZLow_enable = 1'b1;
          end
          C_MULDIV: begin
            rd_field = ra;
            rd_en    = 1'b1;
            Yin      = 1'b1;
          end
          C_IN: begin
            InPortout = 1'b1;
            wr_field  = ra;
            wr_en     = 1'b1;
          end
          C_OUT: begin
            rd_field       = ra;
            rd_en          = 1'b1;
            OutPort_enable = 1'b1;
          end
          C_MFHI: begin
            HIout    = 1'b1;
            wr_field = ra;
            wr_en    = 1'b1;
          end
          C_MFLO: begin
            LOout    = 1'b1;
            wr_field = ra;
            wr_en    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_RTYPE: begin
            rd_field    = rc;
            rd_en       = 1'b1;
            opcode      = op;
            ZLow_enable = 1'b1;
          end
          C_UNARY: begin
            ZLowout  = 1'b1;
            wr_field = ra;
            wr_en    = 1'b1;
          end
          C_MULDIV: begin
            rd_field     = rb;
            rd_en        = 1'b1;
            opcode       = op;
            ZHigh_enable = 1'b1;
            ZLow_enable  = 1'b1;
          end
          C_IMM, C_LD, C_ST: begin
            Cout        = 1'b1;
            opcode      = imm_alu(op);
            ZLow_enable = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_RTYPE, C_IMM: begin
            ZLowout  = 1'b1;
            wr_field = ra;
            wr_en    = 1'b1;
          end
          C_MULDIV: begin
            ZLowout = 1'b1;
            LOin    = 1'b1;
          end
          C_LD, C_ST: begin
            ZLowout    = 1'b1;
            MAR_enable = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MULDIV: begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
          end
          C_LD: begin
            mdr_read = 1'b1;
            MDRin    = 1'b1;
          end
          C_ST: begin
            rd_field = ra;
            rd_en    = 1'b1;
            MDRin    = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin
            MDRout   = 1'b1;
            wr_field = ra;
            wr_en    = 1'b1;
          end
          C_ST: mem_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  reg_field_decoder u_rd_dec (
    .field  (rd_field),
    .en     (rd_en),
    .onehot (reg_out)
  );

  reg_field_decoder u_wr_dec (
    .field  (wr_field),
    .en     (wr_en),
    .onehot (reg_in)
  );

endmodule
